// File: rtl/generic_spi_pkg.sv
// Shared types and frame constants for the generic SPI peripheral model.
package generic_spi_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HEADER = 2'd1,
        WRITE  = 2'd2,
        READ   = 2'd3
    } fsm_state_e;

    localparam int HDR_BITS   = 16;
    localparam int WORD_BITS  = 32;
    localparam int HDR_WR_BIT = 8;

endpackage

// File: rtl/generic_spi_peripheral_sync.sv
// Multi-flop synchronizer with rise/fall detect on the synchronized value.
module spi_input_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   prev_q;
    logic                   prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign q    = sync_q[SYNC_STAGES-1];
    assign rise = q & ~prev_q;
    assign fall = ~q & prev_q;

endmodule

// File: rtl/generic_spi_peripheral.sv
// Oversampled SPI responder: 16b header + 32b data words into a register file.
module generic_spi_peripheral
    import generic_spi_pkg::*;
#(
    parameter int NUM_REGS    = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic        axi_clk,
    input  logic        axi_reset,
    input  logic        spi_clk,
    input  logic        cs_b,
    input  logic        pico,
    output logic        poci,
    input  logic        fab_wr_en,
    input  logic [7:0]  fab_wr_addr,
    input  logic [31:0] fab_wr_data,
    input  logic [7:0]  fab_rd_addr,
    output logic [31:0] fab_rd_data,
    output logic        frame_done,
    output logic [31:0] frame_count,
    output logic        partial_err,
    output logic [1:0]  state_out
);

    localparam int         AW       = $clog2(NUM_REGS);
    localparam logic [7:0] SETTLE   = 8'(SYNC_STAGES + 1);
    localparam logic [4:0] HDR_LAST = 5'(HDR_BITS - 1);
    localparam logic [4:0] WRD_LAST = 5'(WORD_BITS - 1);

    logic sck_q, sck_rise, sck_fall;
    logic cs_q, cs_rise, cs_fall;
    logic pico_q, pico_rise, pico_fall;

    spi_input_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck (
        .clk(axi_clk), .rst(axi_reset), .d(spi_clk),
        .q(sck_q), .rise(sck_rise), .fall(sck_fall)
    );

    spi_input_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs (
        .clk(axi_clk), .rst(axi_reset), .d(cs_b),
        .q(cs_q), .rise(cs_rise), .fall(cs_fall)
    );

    spi_input_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_pico (
        .clk(axi_clk), .rst(axi_reset), .d(pico),
        .q(pico_q), .rise(pico_rise), .fall(pico_fall)
    );

    fsm_state_e        state_q, state_d;
    logic [4:0]        bit_cnt_q, bit_cnt_d;
    logic [AW-1:0]     addr_q, addr_d, addr_inc;
    logic [31:0]       rx_q, rx_d;
    logic [31:0]       tx_q, tx_d;
    logic              poci_q, poci_d;
    logic              done_q, done_d;
    logic [31:0]       count_q, count_d;
    logic              perr_q, perr_d;
    logic              armed_q, armed_d;
    logic [7:0]        settle_q, settle_d;
    logic              settled;
    logic              spi_we;
    logic [31:0]       spi_wdata;
    logic [15:0]       hdr;
    logic [31:0]       regs_q [NUM_REGS];
    logic [31:0]       regs_d [NUM_REGS];
    logic              unused_bits;

    assign addr_inc = addr_q + AW'(1);
    assign settled  = (settle_q == SETTLE);

    // cs_b must be seen high on real (flushed) data before a frame may start
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        addr_d    = addr_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        poci_d    = poci_q;
        done_d    = 1'b0;
        count_d   = count_q;
        perr_d    = perr_q;
        armed_d   = armed_q;
        settle_d  = settle_q;
        spi_we    = 1'b0;
        spi_wdata = rx_q;
        hdr       = '0;
        regs_d    = regs_q;

        if (!settled) settle_d = settle_q + 8'd1;
        if (settled && cs_q) armed_d = 1'b1;
        if (sck_rise) rx_d = {pico_q, rx_q[31:1]};

        unique case (state_q)
            IDLE: begin
                poci_d = 1'b0;
                if (cs_fall && armed_q) begin
                    state_d   = HEADER;
                    bit_cnt_d = '0;
                end
            end
            HEADER: begin
                poci_d = 1'b0;
                if (sck_rise) begin
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == HDR_LAST) begin
                        hdr       = rx_d[31:16];
                        addr_d    = hdr[AW-1:0];
                        tx_d      = regs_q[hdr[AW-1:0]];
                        bit_cnt_d = '0;
                        state_d   = hdr[HDR_WR_BIT] ? WRITE : READ;
                    end
                end
            end
            WRITE: begin
                if (sck_rise) begin
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == WRD_LAST) begin
                        spi_we    = 1'b1;
                        spi_wdata = rx_d;
                        addr_d    = addr_inc;
                        bit_cnt_d = '0;
                    end
                end
            end
            READ: begin
                if (sck_fall) begin
                    poci_d = tx_q[0];
                    tx_d   = {1'b0, tx_q[31:1]};
                end
                if (sck_rise) begin
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == WRD_LAST) begin
                        addr_d    = addr_inc;
                        tx_d      = regs_q[addr_inc];
                        bit_cnt_d = '0;
                    end
                end
            end
        endcase

        // a coincident spi_clk rise has already been applied above
        if (cs_rise) begin
            if (state_q != IDLE) begin
                count_d = count_q + 32'd1;
                if (bit_cnt_d != '0) perr_d = 1'b1;
            end
            state_d   = IDLE;
            bit_cnt_d = '0;
            done_d    = 1'b1;
            poci_d    = 1'b0;
        end

        if (fab_wr_en) regs_d[fab_wr_addr[AW-1:0]] = fab_wr_data;
        if (spi_we) regs_d[addr_q] = spi_wdata;
    end

    always_ff @(posedge axi_clk or posedge axi_reset) begin
        if (axi_reset) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            addr_q    <= '0;
            rx_q      <= '0;
            tx_q      <= '0;
            poci_q    <= 1'b0;
            done_q    <= 1'b0;
            count_q   <= '0;
            perr_q    <= 1'b0;
            armed_q   <= 1'b0;
            settle_q  <= '0;
            regs_q    <= '{default: '0};
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            addr_q    <= addr_d;
            rx_q      <= rx_d;
            tx_q      <= tx_d;
            poci_q    <= poci_d;
            done_q    <= done_d;
            count_q   <= count_d;
            perr_q    <= perr_d;
            armed_q   <= armed_d;
            settle_q  <= settle_d;
            regs_q    <= regs_d;
        end
    end

    assign poci        = poci_q;
    assign frame_done  = done_q;
    assign frame_count = count_q;
    assign partial_err = perr_q;
    assign state_out   = state_q;
    assign fab_rd_data = regs_q[fab_rd_addr[AW-1:0]];

    assign unused_bits = ^{pico_rise, pico_fall, sck_q, rx_q[0],
                           fab_wr_addr, fab_rd_addr, hdr};

endmodule

// File: doc/generic_spi_peripheral.md
Name: generic_spi_peripheral

Overview:
- FPGA-side model of the generic SPI peripheral ASIC control block. It is the responder end of the generic SPI controller link.
- Oversamples cs_b / spi_clk / pico on a single fabric clock and decodes a header plus data frame into a 32b register file. For reads, it shifts register contents back on poci.
- Used for controller loopback and regression without silicon. Registers are also accessible from fabric for checking.

Parameters:
NUM_REGS, 16, number of 32b registers (power of two, 2..256)
SYNC_STAGES, 2, synchronizer depth on spi_clk, cs_b, pico (>=2)

Ports:
axi_clk  in  1  fabric clock; must be >= 4x spi_clk frequency
axi_reset  in  1  asynchronous, active-high reset
spi_clk  in  1  SPI clock from controller (spi_clk_gated)
cs_b  in  1  chip select, active low
pico  in  1  controller-to-peripheral data
poci  out  1  peripheral-to-controller data
fab_wr_en  in  1  fabric register write strobe
fab_wr_addr  in  8  fabric write address (low log2(NUM_REGS) bits used)
fab_wr_data  in  32  fabric write data
fab_rd_addr  in  8  fabric read address
fab_rd_data  out  32  combinational register read
frame_done  out  1  1-cycle pulse at end of each frame
frame_count  out  32  completed frames, wraps at 2^32
partial_err  out  1  sticky: a frame ended mid-word; cleared by reset only
state_out  out  2  current FSM state

Behaviour:
- Reset values:
  - poci=0, frame_done=0, frame_count=0, partial_err=0, state=IDLE.
  - All registers 0. Synchronizer flops preset to spi_clk=0, cs_b=1, pico=0.
- Synchronize spi_clk, cs_b, pico through SYNC_STAGES flops. Edge detect on synced values. All decode acts on detected edges.
- Protocol:
  - Mode 0, LSB first. pico is sampled on spi_clk rise.
  - poci is updated on the axi_clk cycle after a detected spi_clk fall.
  - Frame = 16b header then N x 32b data words.
  - Header bits [7:0] = start address, [8] = write (1) / read (0), [15:9] ignored.
- FSM states (shared enum): IDLE=0, HEADER=1, WRITE=2, READ=3.
  - IDLE -> HEADER on synced cs_b falling edge only. If cs_b is low when reset releases, stay IDLE until cs_b has been seen high.
  - HEADER: shift 16 bits. On the 16th rise -> WRITE or READ. addr_ptr = header[7:0] mod NUM_REGS.
  - WRITE: shift 32 bits. On the 32nd rise, write reg[addr_ptr] and increment addr_ptr modulo NUM_REGS (wrap).
  - READ:
    - On entry, and at each word boundary, snapshot reg[addr_ptr] into the tx shifter.
    - Drive bit k on the fall preceding the k-th rise; bit 0 is driven on the fall after the 16th header rise. Increment addr_ptr (wrap) after 32 bits.
  - Any state, synced cs_b rising edge -> IDLE:
    - frame_done pulses 1 cycle; frame_count increments (only if the frame left IDLE); poci=0.
    - If the bit counter is nonzero in HEADER/WRITE/READ, set partial_err. A partial write word is discarded.
- poci = 0 in IDLE and HEADER.
- Fabric write conflicts:
  - Simultaneous fabric write and SPI commit to the same register: SPI wins.
  - Different registers: both commit.
  - A fabric write after a READ snapshot does not alter bits already in the shifter.
- A cs_b rise coincident with a spi_clk rise: process the rise first, then end the frame.
- Reset asserted mid-frame: immediate return to reset values. No register writes are preserved beyond those already committed.

Decomposition:
- Package generic_spi_pkg holds:
  - FSM_State enum (IDLE/HEADER/WRITE/READ).
  - HDR_BITS=16, WORD_BITS=32, HDR_WR_BIT=8.
- Sub-module spi_input_sync: SYNC_STAGES synchronizer plus rise/fall detect for one signal, instantiated three times.

Test Plan:
- Write frame, header 0x0103 (addr 3, wr) + data 0xDEADBEEF at spi_clk=axi_clk/8 -> reg[3]=0xDEADBEEF; fab_rd_addr=3 returns it; frame_count=1; partial_err=0.
- Fabric writes reg[5]=0x12345678; read frame header 0x0005 + 32 clocks -> poci stream LSB-first yields 0x12345678 at controller; poci=0 during header.
- Burst write from addr NUM_REGS-1 (0x010F) with 2 words 0xA, 0xB -> reg[15]=0xA, reg[0]=0xB (wrap).
- Write frame aborted after 20 data bits (cs_b high) -> target register unchanged; partial_err=1; frame_done pulses once.
- Reset asserted mid-read, released while cs_b low -> no decode until cs_b high; the next full frame works normally.
- Same-cycle fabric write 0x1 and SPI commit 0x2 to reg[7] -> reg[7]=0x2.
